// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback and drives every mux select, write enable and alu_op.
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE_EX, S_RTYPE_WB, S_BEQ_EX, S_JUMP, S_IMM_EX, S_IMM_WB
  } state_t;

  state_t     state, next_state;
  logic [2:0] rtype_op;
  logic       rtype_ok;

  always_comb begin
    rtype_ok = 1'b1;
    rtype_op = ALU_ADD;
    case (funct)
      6'h20:   rtype_op = 3'b010;
      6'h22:   rtype_op = 3'b110;
      6'h24:   rtype_op = 3'b000;
      6'h25:   rtype_op = 3'b001;
      6'h26:   rtype_op = 3'b011;
      6'h27:   rtype_op = 3'b100;
      6'h2A:   rtype_op = 3'b111;
      6'h02:   rtype_op = 3'b101;
      default: rtype_ok = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // NOTE: every output and next_state gets a default before the case, so no
  // path through this block leaves a variable unassigned and no latch appears.
  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_source     = 2'b00;
    illegal       = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:     next_state = rtype_ok ? S_RTYPE_EX : S_FETCH;
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ:       next_state = S_BEQ_EX;
          OP_J:         next_state = S_JUMP;
          OP_ADDI,
          OP_SLTI:      next_state = S_IMM_EX;
          default:      next_state = S_FETCH;
        endcase
        illegal = (next_state == S_FETCH);
      end
      S_MEMADR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_RTYPE_EX: begin
        // SRL shifts rt by shamt, which the datapath takes from sext(imm)[10:6].
        alu_src_a  = (funct == 6'h02) ? 2'b10 : 2'b01;
        alu_src_b  = (funct == 6'h02) ? 2'b10 : 2'b00;
        alu_op     = rtype_op;
        next_state = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ_EX: begin
        alu_src_a     = 2'b01;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        next_state    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        next_state = S_FETCH;
      end
      S_IMM_EX: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        alu_op     = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        next_state = S_IMM_WB;
      end
      S_IMM_WB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset silences the datapath immediately, even mid-instruction.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = ALU_ADD;
      pc_source     = 2'b00;
      illegal       = 1'b0;
    end
  end

endmodule
